// File: rtl/dvp_pixel_packer.sv
// DVP byte stream to 32-bit little-endian AXI4-Stream words, with frame/line
// framing (tuser = start of frame, tlast = end of line) and a small output FIFO.
module dvp_pixel_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             capture_en,
  input  logic             ovf_clr,
  input  logic             dvp_vsync,
  input  logic             dvp_href,
  input  logic             dvp_de,
  input  logic [7:0]       dvp_data,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             frame_done,
  output logic             overflow,
  output logic [CNT_W-1:0] line_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_FLUSH} state_t;

  state_t state_q, state_d;
  logic vs_q, hr_q, de_q, vs_prev_q, hr_prev_q;
  logic [7:0] dat_q;
  logic [1:0] idx_q, idx_d;
  logic [31:0] word_q, word_d, pend_q, pend_d;
  logic pend_valid_q, pend_valid_d, part_pend_q, part_pend_d;
  logic line_has_q, line_has_d, sof_q, sof_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, line_cnt_q, line_cnt_d;
  logic [33:0] mem_q [FIFO_DEPTH];
  logic [33:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic valid_q, valid_d;

  logic vs_fall, vs_rise, hr_fall;
  logic accept, line_end, frame_start, flush_done;
  logic push, push_last, full, push_ok, pop;
  logic [31:0] push_data;

  assign vs_fall = vs_prev_q & ~vs_q;
  assign vs_rise = ~vs_prev_q & vs_q;
  assign hr_fall = hr_prev_q & ~hr_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vs_q      <= 1'b0;
      hr_q      <= 1'b0;
      de_q      <= 1'b0;
      dat_q     <= 8'd0;
      vs_prev_q <= 1'b0;
      hr_prev_q <= 1'b0;
    end else begin
      vs_q      <= dvp_vsync;
      hr_q      <= dvp_href;
      de_q      <= dvp_de;
      dat_q     <= dvp_data;
      vs_prev_q <= vs_q;
      hr_prev_q <= hr_q;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (capture_en) state_d = S_SYNC;
      S_SYNC:   if (!capture_en) state_d = S_IDLE;
                else if (vs_fall) state_d = S_ACTIVE;
      S_ACTIVE: if (vs_rise) state_d = S_FLUSH;
      S_FLUSH:  if (!part_pend_q) state_d = capture_en ? S_SYNC : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A byte arriving in the same cycle as the vsync rise belongs to no line.
  always_comb begin
    frame_start = (state_q == S_SYNC) && capture_en && vs_fall;
    flush_done  = (state_q == S_FLUSH) && !part_pend_q;
    accept      = (state_q == S_ACTIVE) && de_q && hr_q && !vs_rise;
    line_end    = (state_q == S_ACTIVE) && (hr_fall || (vs_rise && hr_q));
  end

  always_comb begin
    idx_d        = idx_q;
    word_d       = word_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    part_pend_d  = part_pend_q;
    line_has_d   = line_has_q;
    sof_d        = sof_q;
    run_cnt_d    = run_cnt_q;
    push         = 1'b0;
    push_data    = pend_q;
    push_last    = 1'b0;

    if (vs_fall) run_cnt_d = '0;
    if (frame_start) begin
      idx_d        = 2'd0;
      pend_valid_d = 1'b0;
      line_has_d   = 1'b0;
      sof_d        = 1'b1;
    end

    if (part_pend_q) begin
      push        = 1'b1;
      push_data   = word_q;
      push_last   = 1'b1;
      part_pend_d = 1'b0;
    end

    if (accept) begin
      line_has_d = 1'b1;
      if (pend_valid_q) begin
        push         = 1'b1;
        pend_valid_d = 1'b0;
      end
      if (idx_q == 2'd0) word_d = {24'd0, dat_q};
      else               word_d[{idx_q, 3'b000} +: 8] = dat_q;
      if (idx_q == 2'd3) begin
        pend_d       = {dat_q, word_q[23:0]};
        pend_valid_d = 1'b1;
      end
      idx_d = idx_q + 2'd1;
    end

    // Full word closes the line directly; a partial word follows one cycle later.
    if (line_end && line_has_q) begin
      if (pend_valid_q) begin
        push      = 1'b1;
        push_last = (idx_q == 2'd0);
      end
      pend_valid_d = 1'b0;
      part_pend_d  = (idx_q != 2'd0);
      idx_d        = 2'd0;
      line_has_d   = 1'b0;
      if (run_cnt_q != '1) run_cnt_d = run_cnt_q + 1'b1;
    end

    if (push_ok) sof_d = 1'b0;
  end

  always_comb begin
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    push_ok  = push && !full;
    pop      = valid_q && m_axis_tready;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = {sof_q, push_last, push_data};
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    valid_d  = (count_d != '0);
    ovf_d    = (push && full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    line_cnt_d = flush_done ? run_cnt_q : line_cnt_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx_q        <= 2'd0;
      word_q       <= 32'd0;
      pend_q       <= 32'd0;
      pend_valid_q <= 1'b0;
      part_pend_q  <= 1'b0;
      line_has_q   <= 1'b0;
      sof_q        <= 1'b0;
      run_cnt_q    <= '0;
      line_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      word_q       <= word_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      part_pend_q  <= part_pend_d;
      line_has_q   <= line_has_d;
      sof_q        <= sof_d;
      run_cnt_q    <= run_cnt_d;
      line_cnt_q   <= line_cnt_d;
      ovf_q        <= ovf_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
    end
  end

  logic [33:0] head;
  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = valid_q ? head[31:0] : 32'd0;
  assign m_axis_tlast  = valid_q & head[32];
  assign m_axis_tuser  = valid_q & head[33];
  assign frame_done    = flush_done;
  assign overflow      = ovf_q;
  assign line_cnt      = line_cnt_q;
endmodule

// File: doc/dvp_pixel_packer.md
# dvp_pixel_packer

Capture front-end that sits directly upstream of the DVP-to-DDR write stage. It takes camera DVP byte traffic that has already been re-timed into the `ACLK` domain, frames it with `vsync` and `href`, and packs the bytes into 32-bit little-endian words. Output is an AXI4-Stream master buffered by a small FIFO: `tuser` marks start of frame and `tlast` marks end of line. The DDR burst writer consumes this stream, and the AXI4-Lite register block drives `capture_en`, `ovf_clr` and reads the status outputs.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: output FIFO depth in 32-bit words, power of two, ≥4.
- `CNT_W`, default 12: width of the line and byte counters.

Ports:
- `ACLK` in 1: the block's single clock.
- `ARESET` in 1: asynchronous, active-high reset.
- `capture_en` in 1: level; arms capture.
- `ovf_clr` in 1: one-cycle pulse; clears `overflow`.
- `dvp_vsync` in 1: frame sync; high = blanking.
- `dvp_href` in 1: line valid.
- `dvp_de` in 1: byte strobe, one cycle per camera byte.
- `dvp_data` in 8: camera byte.
- `m_axis_tdata` out 32: packed word.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last word of line.
- `m_axis_tuser` out 1: first word of frame.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `overflow` out 1: sticky; set when a word is dropped.
- `line_cnt` out CNT_W: lines in the last completed frame.

## Operation
- Input stage: `dvp_vsync`, `dvp_href`, `dvp_de` and `dvp_data` are registered once. Edges are detected against the previous registered value.
- A byte is accepted when registered `de` = 1, registered `href` = 1 and the state is ACTIVE.
- State machine (reset → IDLE):
  - IDLE: ignore input. If `capture_en` = 1 → SYNC.
  - SYNC: wait for a `vsync` falling edge → ACTIVE, set `sof_pending`. A frame already in progress is never joined mid-frame.
  - ACTIVE: on a `vsync` rising edge, flush (see below), pulse `frame_done`, latch `line_cnt`. Then go → SYNC if `capture_en` = 1, else → IDLE.
  - Deasserting `capture_en` mid-frame does not abort the frame; it is checked only at frame end.
- Packing:
  - Byte index `idx` runs 0..3. Byte k lands in `tdata[8k+7:8k]`.
  - Completing byte 3 moves the word into a staging register `pend`.
  - `pend` is pushed with `tlast` = 0 when the next accepted byte arrives.
- Line end (`href` falling edge, or `vsync` rising edge while `href` is high), for a line with ≥1 byte:
  - If `idx` = 0: push `pend` with `tlast` = 1.
  - If `idx` ≠ 0: push `pend` with `tlast` = 0, then on the next cycle push the partial word, zero-padded in the upper bytes, with `tlast` = 1.
  - Increment the running line counter. A line with 0 bytes produces nothing and is not counted.
- `tuser` = `sof_pending` on each push; `sof_pending` clears on the first successful push.
- FIFO:
  - Fall-through with a registered output.
  - Full is evaluated before the same-cycle pop. A push while full drops the word and sets `overflow`.
  - A dropped `tuser` word leaves `sof_pending` set.
- `overflow`:
  - Cleared by `ovf_clr`. If set and clear occur in the same cycle, set wins.
  - Overflow never stalls packing.
- `line_cnt` saturates at 2^CNT_W−1. The running counter resets at each `vsync` falling edge.

## Timing
- Reset values: all outputs 0, FIFO empty, `pend` invalid, `idx` = 0, state IDLE. Reset mid-line discards all buffered data.
- Latency from byte at the DVP input to its accepted state: 1 cycle (input register).
- Line-end push timing:
  - Last byte in cycle t and `href` low in cycle t+1: `tlast` word pushed at the end of cycle t+2 (t+3 when a partial word exists).
  - `tvalid` rises the cycle after the push.
- Input constraint: `href` and `vsync` must stay low/high for ≥3 cycles between lines/frames. Behaviour outside this constraint is undefined.
- AXI-Stream rules: `tdata`, `tlast` and `tuser` are stable while `tvalid` = 1 and `tready` = 0. A transfer occurs on `tvalid` & `tready`.
- `frame_done` is asserted in the cycle after the final push of the frame, or in the cycle after the `vsync` edge is processed if the frame had no data.

## Test plan
- One line of 8 bytes 0x01..0x08, `tready` = 1 → words 0x04030201 (`tuser` = 1, `tlast` = 0) then 0x08070605 (`tuser` = 0, `tlast` = 1). After the `vsync` rise: `frame_done` pulses once and `line_cnt` = 1.
- Line of 6 bytes 0xA0..0xA5 → 0xA3A2A1A0 (`tlast` = 0) then 0x0000A5A4 (`tlast` = 1). Next line 0xB0..0xB3 → 0xB3B2B1B0 (`tlast` = 1). `line_cnt` = 2.
- `tready` = 0, `FIFO_DEPTH` = 16, line of 80 bytes → exactly 16 words held (first is 0x03020100-pattern), 4 dropped, `overflow` = 1. Then `tready` = 1 drains 16 words in order, and `ovf_clr` returns `overflow` to 0.
- `capture_en` raised mid-frame (`vsync` low, `href` active) → no output until the next `vsync` fall. `capture_en` dropped mid-frame → that frame completes with `frame_done`, and the following frame produces no words.
- Line of 4 bytes ending by a `vsync` rise while `href` = 1 → single word with `tlast` = 1, then `frame_done`.
- `ARESET` pulsed mid-line with 3 words queued → `tvalid` = 0 immediately, all outputs 0. The next frame starts with `tuser` = 1 and no stale data.
